bcd_chain_counter: RTL and testbench

Parametrised multi-digit modulo-RADIX up/down counter: the generalised successor to the team's single-digit decade counter. Counts DIGITS cascaded digits, each modulo RADIX, with enable, direction, synchronous clear and parallel load. It raises a combinational carry for cascading and a sticky wrap flag. Used wherever the design needs decimal or other non-binary event or time counting, such as display timers and event tallies.

---
 rtl/bcd_chain_pkg.sv | 19 +
 rtl/radix_digit.sv | 43 ++++
 rtl/bcd_chain_counter.sv | 92 +++++++++
 tb/tb_bcd_chain_counter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_chain_pkg.sv
// Shared constants and parameter-legality check for the modulo-RADIX chain counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_chain_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int RADIX_DEF  = 10;
  localparam int DW_DEF     = 4;

  // True when the digit count, radix and digit width form a usable counter:
  // 1..8 digits, radix 2..16, and every digit value 0..RADIX-1 fits in DW bits.
  function automatic bit params_ok(int digits, int radix, int dw);
    return (digits >= 1) && (digits <= 8) &&
           (radix >= 2) && (radix <= 16) &&
           (dw >= 1) && (dw <= 30) &&
           (radix <= (1 << dw));
  endfunction

endpackage

// File: rtl/radix_digit.sv
// One modulo-RADIX digit register of the chain counter.
// Latency: q updates one cycle after step/clear/load; is_term is combinational from q and up.
// Backpressure: none; a step is taken on every cycle it is asserted.
// Ports: clk, reset_n (async active-low); step/up/clear/load/ld_val control inputs;
//        q = digit value, is_term = digit sits at its terminal value for direction up.
module radix_digit
  import bcd_chain_pkg::*;
#(
  parameter int RADIX = RADIX_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          step,
  input  logic          up,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] q,
  output logic          is_term
);

  localparam logic [DW-1:0] TOP = DW'(RADIX - 1);

  assign is_term = up ? (q == TOP) : (q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= ld_val;
    end else if (step) begin
      if (up) begin
        q <= (q == TOP) ? '0 : q + DW'(1);
      end else begin
        q <= (q == '0) ? TOP : q - DW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_chain_counter.sv
// Multi-digit modulo-RADIX up/down counter with clear, saturating load, carry out and sticky wrap flag.
// Latency: count/wrapped/load_err are registered (1 cycle); carry is combinational.
// Backpressure: none; steps once per cycle with en=1, cascade by wiring carry to the next en.
// Ports: clk, reset_n (async active-low); en, up, clear, load, load_val (digit i at [i*DW +: DW]);
//        count (same packing), carry, wrapped (sticky), load_err (one-cycle pulse).
module bcd_chain_counter
  import bcd_chain_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int RADIX  = RADIX_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 carry,
  output logic                 wrapped,
  output logic                 load_err
);

  if (!params_ok(DIGITS, RADIX, DW)) begin : g_param_check
    $error("bcd_chain_counter: illegal DIGITS/RADIX/DW combination");
  end

  localparam logic [DW-1:0] TOP = DW'(RADIX - 1);

  logic [DIGITS-1:0]    is_term;
  logic [DIGITS-1:0]    step;
  logic [DIGITS-1:0]    bad_digit;
  logic [DIGITS:0]      all_below;  // all_below[i]: digits 0..i-1 are terminal
  logic [DIGITS*DW-1:0] ld_sat;
  logic                 advance;

  assign advance = en & ~clear & ~load;

  // Prefix AND over the terminal flags; every digit's enable is formed
  // directly from the flags below it rather than rippling through registers.
  always_comb begin
    all_below[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_below[i+1] = all_below[i] & is_term[i];
    end
  end

  // The full chain wraps exactly when a step is taken with every digit terminal.
  assign carry = advance & all_below[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    // Illegal load digits saturate to RADIX-1 so count never shows a value >= RADIX.
    assign bad_digit[g]         = int'(load_val[g*DW +: DW]) >= RADIX;
    assign ld_sat[g*DW +: DW]   = bad_digit[g] ? TOP : load_val[g*DW +: DW];
    assign step[g]              = advance & all_below[g];

    radix_digit #(
      .RADIX(RADIX),
      .DW   (DW)
    ) u_digit (
      .clk    (clk),
      .reset_n(reset_n),
      .step   (step[g]),
      .up     (up),
      .clear  (clear),
      .load   (load),
      .ld_val (ld_sat[g*DW +: DW]),
      .q      (count[g*DW +: DW]),
      .is_term(is_term[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrapped  <= 1'b0;
      load_err <= 1'b0;
    end else if (clear) begin
      wrapped  <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      load_err <= |bad_digit;  // wrapped deliberately untouched by a load
    end else begin
      load_err <= 1'b0;
      if (carry) begin
        wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Self-checking bench: a 4-digit decimal counter and a 2-digit radix-6 counter share stimulus.
// Reference model keeps each counter as a plain integer modulo RADIX**DIGITS.
// Ports of both instances are fully connected; clock period 10.
module tb_bcd_chain_counter;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        en       = 1'b0;
  logic        up       = 1'b1;
  logic        clear    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] count_a;
  logic        carry_a, wrapped_a, load_err_a;
  logic [7:0]  count_b;
  logic        carry_b, wrapped_b, load_err_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: integer value, sticky wrap, load error pulse.
  int va = 0;
  int vb = 0;
  bit wa = 1'b0, wb = 1'b0, ea = 1'b0, eb = 1'b0;

  always #5 clk = ~clk;

  bcd_chain_counter #(.DIGITS(4), .RADIX(10), .DW(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_a), .carry(carry_a), .wrapped(wrapped_a),
    .load_err(load_err_a)
  );

  bcd_chain_counter #(.DIGITS(2), .RADIX(6), .DW(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val[7:0]), .count(count_b), .carry(carry_b), .wrapped(wrapped_b),
    .load_err(load_err_b)
  );

  // ---------------- reference model ----------------
  function automatic int modn(int d, int r);
    int m = 1;
    for (int i = 0; i < d; i++) m = m * r;
    return m;
  endfunction

  function automatic logic [31:0] enc(int v, int d, int r);
    logic [31:0] o = '0;
    int t = v;
    for (int i = 0; i < d; i++) begin
      o[i*4 +: 4] = 4'(t % r);
      t = t / r;
    end
    return o;
  endfunction

  function automatic int ld_num(logic [15:0] lv, int d, int r);
    int v = 0;
    for (int i = d - 1; i >= 0; i--) begin
      int dig;
      dig = int'(lv[i*4 +: 4]);
      if (dig >= r) dig = r - 1;
      v = v * r + dig;
    end
    return v;
  endfunction

  function automatic bit ld_bad(logic [15:0] lv, int d, int r);
    bit b = 1'b0;
    for (int i = 0; i < d; i++) begin
      if (int'(lv[i*4 +: 4]) >= r) b = 1'b1;
    end
    return b;
  endfunction

  function automatic bit exp_carry(int v, int d, int r, bit c, bit l, bit e, bit u);
    int m = modn(d, r);
    return !c && !l && e && (u ? (v == m - 1) : (v == 0));
  endfunction

  function automatic int nxt_v(int v, int d, int r, bit c, bit l, bit e, bit u, logic [15:0] lv);
    int m = modn(d, r);
    if (c) return 0;
    if (l) return ld_num(lv, d, r);
    if (!e) return v;
    if (u) return (v == m - 1) ? 0 : v + 1;
    return (v == 0) ? m - 1 : v - 1;
  endfunction

  function automatic bit nxt_w(bit w, int v, int d, int r, bit c, bit l, bit e, bit u);
    if (c) return 1'b0;
    return w || exp_carry(v, d, r, c, l, e, u);
  endfunction

  function automatic bit nxt_e(logic [15:0] lv, int d, int r, bit c, bit l);
    if (c || !l) return 1'b0;
    return ld_bad(lv, d, r);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      va <= 0; wa <= 1'b0; ea <= 1'b0;
      vb <= 0; wb <= 1'b0; eb <= 1'b0;
    end else begin
      va <= nxt_v(va, 4, 10, clear, load, en, up, load_val);
      wa <= nxt_w(wa, va, 4, 10, clear, load, en, up);
      ea <= nxt_e(load_val, 4, 10, clear, load);
      vb <= nxt_v(vb, 2, 6, clear, load, en, up, load_val);
      wb <= nxt_w(wb, vb, 2, 6, clear, load, en, up);
      eb <= nxt_e(load_val, 2, 6, clear, load);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  // Registered outputs checked on the falling edge; carry checked after the
  // inputs for the coming edge have been applied.
  initial begin
    @(posedge reset_n);
    forever begin
      @(negedge clk);
      chk("a_count",    32'(count_a),    enc(va, 4, 10));
      chk("a_wrapped",  32'(wrapped_a),  32'(wa));
      chk("a_load_err", 32'(load_err_a), 32'(ea));
      chk("b_count",    32'(count_b),    enc(vb, 2, 6));
      chk("b_wrapped",  32'(wrapped_b),  32'(wb));
      chk("b_load_err", 32'(load_err_b), 32'(eb));
      chk("b_digit_range", 32'((count_b[7:4] < 4'd6) && (count_b[3:0] < 4'd6)), 32'd1);
      #3;
      chk("a_carry", 32'(carry_a), 32'(exp_carry(va, 4, 10, clear, load, en, up)));
      chk("b_carry", 32'(carry_b), 32'(exp_carry(vb, 2, 6, clear, load, en, up)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit c, bit l, bit e, bit u, logic [15:0] lv);
    @(negedge clk);
    #1;
    clear    = c;
    load     = l;
    en       = e;
    up       = u;
    load_val = lv;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ud;
    #22 reset_n = 1'b1;

    // Asynchronous reset from a non-zero count, no clock edge needed.
    drive(0, 1, 0, 1, 16'h0123);
    settle();
    chk("t1_loaded", 32'(count_a), 32'h0123);
    drive(0, 0, 0, 1, 16'h0000);
    #1 reset_n = 1'b0;
    #1;
    chk("t1_async_count",   32'(count_a),   32'h0000);
    chk("t1_async_wrapped", 32'(wrapped_a), 32'h0);
    #1 reset_n = 1'b1;

    // Up cascade and full wrap.
    drive(0, 1, 0, 1, 16'h0199);
    drive(0, 0, 1, 1, 16'h0000);
    settle();
    chk("t2_cascade", 32'(count_a), 32'h0200);
    drive(0, 1, 0, 1, 16'h9999);
    drive(0, 0, 1, 1, 16'h0000);
    #1;
    chk("t2_carry_hi", 32'(carry_a), 32'h1);
    settle();
    chk("t2_wrap_count",   32'(count_a),   32'h0000);
    chk("t2_wrap_flag",    32'(wrapped_a), 32'h1);
    drive(0, 0, 1, 1, 16'h0000);
    #1;
    chk("t2_carry_lo", 32'(carry_a), 32'h0);

    // Down cascade and wrap from zero.
    drive(0, 1, 0, 0, 16'h1000);
    settle();
    chk("t3_load_keeps_wrap", 32'(wrapped_a), 32'h1);
    drive(0, 0, 1, 0, 16'h0000);
    settle();
    chk("t3_borrow", 32'(count_a), 32'h0999);
    drive(1, 0, 0, 0, 16'h0000);
    settle();
    chk("t3_clear_count", 32'(count_a),   32'h0000);
    chk("t3_clear_wrap",  32'(wrapped_a), 32'h0);
    drive(0, 0, 1, 0, 16'h0000);
    #1;
    chk("t3_carry_down", 32'(carry_a), 32'h1);
    settle();
    chk("t3_down_wrap_count", 32'(count_a),   32'h9999);
    chk("t3_down_wrap_flag",  32'(wrapped_a), 32'h1);

    // Illegal digits saturate, error pulses for one cycle.
    drive(0, 1, 0, 1, 16'h3A7F);
    settle();
    chk("t4_sat_count", 32'(count_a),    32'h3979);
    chk("t4_err_pulse", 32'(load_err_a), 32'h1);
    chk("t4_wrap_kept", 32'(wrapped_a),  32'h1);
    chk("t4_b_sat",     32'(count_b),    32'h55);
    drive(0, 0, 0, 1, 16'h0000);
    settle();
    chk("t4_err_gone", 32'(load_err_a), 32'h0);

    // Priority: clear over load over en.
    drive(0, 1, 0, 1, 16'h0555);
    drive(1, 1, 1, 1, 16'h0123);
    settle();
    chk("t5_clear_wins", 32'(count_a),   32'h0000);
    chk("t5_clear_wrap", 32'(wrapped_a), 32'h0);
    drive(0, 1, 1, 1, 16'h0042);
    #1;
    chk("t5_carry_load", 32'(carry_a), 32'h0);
    settle();
    chk("t5_load_wins", 32'(count_a), 32'h0042);

    // Radix-6, two digits: period of 36 steps.
    drive(1, 0, 0, 1, 16'h0000);
    for (int i = 0; i < 35; i++) drive(0, 0, 1, 1, 16'h0000);
    settle();
    chk("t6_top",        32'(count_b),   32'h55);
    chk("t6_no_wrap",    32'(wrapped_b), 32'h0);
    drive(0, 0, 1, 1, 16'h0000);
    settle();
    chk("t6_wrap_count", 32'(count_b),   32'h00);
    chk("t6_wrap_flag",  32'(wrapped_b), 32'h1);
    for (int i = 0; i < 24; i++) drive(0, 0, 1, 1, 16'h0000);
    settle();
    chk("t6_sixty", 32'(count_b), 32'h40);

    // Randomised traffic with long direction runs and edge-heavy load values.
    ud = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] lv;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 15) == 0) ud = ~ud;
      case ($urandom_range(0, 3))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        default: begin
          for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 15) < 13) lv[d*4 +: 4] = 4'($urandom_range(0, 9));
            else                            lv[d*4 +: 4] = 4'($urandom_range(10, 15));
          end
        end
      endcase
      drive(r < 3, (r >= 3) && (r < 12), $urandom_range(0, 3) != 0, ud, lv);
    end

    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
